pdp_fetch_queue: RTL and testbench
==================================

# pdp_fetch_queue

Instruction fetch stage for the PDP-11 core. Reads 16-bit instruction words from the program flash, tracks the program counter (byte address, +2 per word), buffers fetched words in a small prefetch queue and hands them to the decode stage over a valid/ready handshake. Accepts PC redirects from the execute stage for branches and jumps, and stops fetching on HALT (16'o000000) or on an out-of-range fetch.

## Interface
Parameters:
- `PC_WIDTH`, 16: width of the byte-address PC.
- `FLASH_DEPTH`, 2048: flash size in 16-bit words. Word address width `FA_W = $clog2(FLASH_DEPTH)`.
- `QUEUE_DEPTH`, 4: prefetch queue entries. Must be a power of two and at least 2.
- `RESET_PC`, 16'o000000: PC loaded on reset.

Ports:
- `clock`  in  1  — the single clock.
- `reset`  in  1  — asynchronous, active-high reset.
- `flash_rd`  out  1  — read strobe. Data is returned one cycle later.
- `flash_addr`  out  FA_W  — word address, equal to `fetch_pc[FA_W:1]`.
- `flash_rdata`  in  16  — read data, valid in the cycle after `flash_rd`.
- `redirect_valid`  in  1  — load a new PC (taken branch or jump).
- `redirect_pc`  in  PC_WIDTH  — new PC. Bit 0 is ignored and forced to 0.
- `dec_valid`  out  1  — queue head is valid.
- `dec_ready`  in  1  — decode consumes the head when `dec_valid && dec_ready`.
- `dec_instr`  out  16  — head instruction word.
- `dec_pc`  out  PC_WIDTH  — byte address of the head instruction.
- `dec_next_pc`  out  PC_WIDTH  — `dec_pc + 2`, modulo 2^PC_WIDTH.
- `halted`  out  1  — fetch is stopped by HALT or fault.
- `fetch_fault`  out  1  — the PC left the flash range.

## Operation
- State machine `fetch_state_t`:
  - RUN: issue reads.
  - HALT: stopped by a HALT word.
  - FAULT: stopped by an out-of-range PC.
  - Reset enters RUN with `fetch_pc = RESET_PC`.
- Issue rule: in RUN, `flash_rd = 1` when all of these hold:
  - `occupancy + inflight < QUEUE_DEPTH`;
  - `redirect_valid == 0`;
  - `fetch_pc[PC_WIDTH-1:1] < FLASH_DEPTH`.
  - On issue, `fetch_pc += 2` and `inflight` is set to 1. `inflight` is at most 1, because latency is fixed at 1.
- Out of range: in RUN with an out-of-range PC, go to FAULT. `fetch_fault = 1` and `halted = 1`. No read is issued.
- Response: in the cycle after an issue, if the epoch still matches, `{flash_rdata, issued_pc}` is written to the queue tail.
- HALT detection: if the written word equals 16'o000000, go to HALT. The HALT word itself is enqueued and delivered, because decode must see it. No further reads are issued.
- In HALT or FAULT, the queue keeps draining normally.
- Redirect (any state), at the edge ending the cycle:
  - the queue is flushed;
  - any in-flight response is discarded by toggling a 1-bit epoch;
  - `fetch_pc = {redirect_pc[PC_WIDTH-1:1], 1'b0}`;
  - state returns to RUN and `fetch_fault` clears.
- Priorities:
  - Redirect beats dequeue, enqueue and issue.
  - A simultaneous dequeue and enqueue is legal when the queue is full, and occupancy is unchanged.
- Decode outputs come straight from the head register. They hold stable while `dec_valid && !dec_ready`.
- Wrap-around: PC arithmetic is modulo 2^PC_WIDTH. With the default widths, PC 16'o177776 + 2 = 0, but that PC is already out of range and so faults first.
- Reset values:
  - `flash_rd = 0`, `dec_valid = 0`, `halted = 0`, `fetch_fault = 0`;
  - queue empty, `inflight = 0`, epoch 0;
  - `dec_instr`, `dec_pc` and `dec_next_pc` are 0.

## Timing
- The first read is issued in the first clock after reset deasserts.
- Issue in cycle t → data enqueued at the end of t+1 → `dec_valid` high in cycle t+2. There is no bypass.
- Throughput: with `dec_ready` held high, one instruction per cycle.
- Redirect in cycle N:
  - `dec_valid = 0` in cycle N+1;
  - the read of the new PC is issued in N+1;
  - the first new instruction is valid in N+3.
- HALT word enqueued at edge E: `halted = 1` from E onward. `flash_rd` is never asserted after E until a redirect.
- Reset asserted mid-operation: all state clears immediately, without waiting for a clock edge. A response still pending from flash is ignored.

## Structure
- Add to package `parameters`:
  - `fetch_state_t` {RUN, HALT, FAULT};
  - `HALT_OPCODE = 16'o000000`;
  - struct `fetch_entry_t` {`instr[15:0]`, `pc[PC_WIDTH-1:0]`}.
- Sub-module `pdp_fetch_fifo`: a synchronous FIFO of `fetch_entry_t` with a flush input, count output, and async active-high reset.
- The top level holds the PC, the inflight/epoch logic and the state machine.

## Test plan
- Sequential fetch: flash[0..3] = 16'o060001, 16'o060000, 16'o027654, 16'o000000; `dec_ready = 1`.
  - Expect `dec_pc` = 0, 2, 4, 6 on consecutive cycles starting at cycle 2.
  - `halted` rises when the HALT word is enqueued.
  - No `flash_rd` after the address-3 read.
- Backpressure: `dec_ready = 0` for 10 cycles.
  - Exactly `QUEUE_DEPTH` (4) reads are issued.
  - The head holds 16'o060001 at PC 0, stable.
  - On release, the 4 entries drain in order and fetch resumes at PC 8.
- Redirect with a read in flight: assert `redirect_valid` with `redirect_pc = 16'o000021` in cycle 5.
  - Queue is flushed and the stale response is dropped.
  - Next `dec_pc = 16'o000020` in cycle 8, and `dec_instr = flash[8]`.
- Out of range: `redirect_pc = 16'o010000` (word 2048).
  - `fetch_fault = 1` and `halted = 1`, no `flash_rd`, `dec_valid` stays 0.
  - A subsequent redirect to 0 recovers.
- Full queue with simultaneous dequeue and enqueue: occupancy stays 4, order is preserved, and no entry is lost or duplicated.
- Reset mid-run: assert `reset` asynchronously between edges while the queue is full.
  - Outputs clear immediately.
  - After release, `dec_pc = RESET_PC` is valid in cycle 2.

Source files
------------

// File: rtl/pdp_fetch_queue_pkg.sv
// Shared types and constants for the PDP-11 instruction fetch stage.
package pdp_fetch_queue_pkg;

   localparam int unsigned ENTRY_PC_W = 16;

   localparam logic [15:0] HALT_OPCODE = 16'o000000;

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      HALT  = 2'd1,
      FAULT = 2'd2
   } fetch_state_t;

   typedef struct packed {
      logic [15:0]           instr;
      logic [ENTRY_PC_W-1:0] pc;
   } fetch_entry_t;

endpackage

// File: rtl/pdp_fetch_fifo.sv
// Prefetch queue: synchronous FIFO of fetched words with flush and occupancy count.
module pdp_fetch_fifo
   import pdp_fetch_queue_pkg::*;
#(
   parameter int unsigned Depth = 4,
   localparam int unsigned AW = $clog2(Depth)
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         flush_i,
   input  logic         push_i,
   input  fetch_entry_t wdata_i,
   input  logic         pop_i,
   output fetch_entry_t head_o,
   output logic [AW:0]  count_o
);

   fetch_entry_t  mem_q [Depth];
   logic [AW-1:0] rd_ptr_q;
   logic [AW-1:0] wr_ptr_q;
   logic [AW:0]   count_q;
   logic          do_push;
   logic          do_pop;

   assign do_pop  = pop_i && (count_q != '0);
   // A push into a full queue is accepted when the head leaves in the same cycle.
   assign do_push = push_i && ((count_q != (AW+1)'(Depth)) || do_pop);

   assign head_o  = mem_q[rd_ptr_q];
   assign count_o = count_q;

   // Pointers wrap naturally because Depth is a power of two.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int i = 0; i < int'(Depth); i++) begin
            mem_q[i] <= '0;
         end
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else if (flush_i) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
            wr_ptr_q        <= wr_ptr_q + 1'b1;
         end
         if (do_pop) begin
            rd_ptr_q <= rd_ptr_q + 1'b1;
         end
         count_q <= count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
      end
   end

endmodule

// File: rtl/pdp_fetch_queue.sv
// PDP-11 fetch stage: PC, one-deep flash read pipeline with epoch tagging, run/halt/fault FSM.
module pdp_fetch_queue
   import pdp_fetch_queue_pkg::*;
#(
   parameter int unsigned PC_WIDTH    = 16,
   parameter int unsigned FLASH_DEPTH = 2048,
   parameter int unsigned QUEUE_DEPTH = 4,
   parameter logic [PC_WIDTH-1:0] RESET_PC = 16'o000000,
   localparam int unsigned FA_W = $clog2(FLASH_DEPTH)
) (
   input  logic                clock,
   input  logic                reset,
   output logic                flash_rd,
   output logic [FA_W-1:0]     flash_addr,
   input  logic [15:0]         flash_rdata,
   input  logic                redirect_valid,
   input  logic [PC_WIDTH-1:0] redirect_pc,
   output logic                dec_valid,
   input  logic                dec_ready,
   output logic [15:0]         dec_instr,
   output logic [PC_WIDTH-1:0] dec_pc,
   output logic [PC_WIDTH-1:0] dec_next_pc,
   output logic                halted,
   output logic                fetch_fault
);

   localparam int unsigned QW = $clog2(QUEUE_DEPTH);
   localparam logic [QW:0] QDepth = (QW+1)'(QUEUE_DEPTH);

   fetch_state_t        state_q;
   logic [PC_WIDTH-1:0] fetch_pc_q;
   logic [PC_WIDTH-1:0] issued_pc_q;
   logic                inflight_q;
   logic                epoch_q;
   logic                issue_epoch_q;

   logic [QW:0]  occupancy;
   fetch_entry_t head;
   fetch_entry_t wentry;
   logic         in_range;
   logic         resp_live;
   logic         resp_halt;
   logic         issue;
   logic         push;
   logic         pop;
   logic         unused_pc_lsb;

   assign unused_pc_lsb = redirect_pc[0];

   assign in_range  = {1'b0, fetch_pc_q[PC_WIDTH-1:1]} < PC_WIDTH'(FLASH_DEPTH);
   assign resp_live = inflight_q && (issue_epoch_q == epoch_q);
   // A HALT word arriving now stops fetch before the next read goes out.
   assign resp_halt = resp_live && (flash_rdata == HALT_OPCODE);

   assign issue = !reset && (state_q == RUN) && !redirect_valid && in_range && !resp_halt &&
                  ((occupancy + {{QW{1'b0}}, inflight_q}) < QDepth);

   assign push   = resp_live && !redirect_valid;
   assign pop    = dec_valid && dec_ready;
   assign wentry = '{instr: flash_rdata, pc: issued_pc_q};

   assign flash_rd    = issue;
   assign flash_addr  = fetch_pc_q[FA_W:1];
   assign dec_valid   = (occupancy != '0);
   assign dec_instr   = dec_valid ? head.instr : '0;
   assign dec_pc      = dec_valid ? head.pc : '0;
   assign dec_next_pc = dec_valid ? head.pc + PC_WIDTH'(2) : '0;
   assign halted      = (state_q != RUN);
   assign fetch_fault = (state_q == FAULT);

   pdp_fetch_fifo #(
      .Depth (QUEUE_DEPTH)
   ) u_fifo (
      .clk_i   (clock),
      .rst_i   (reset),
      .flush_i (redirect_valid),
      .push_i  (push),
      .wdata_i (wentry),
      .pop_i   (pop),
      .head_o  (head),
      .count_o (occupancy)
   );

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q       <= RUN;
         fetch_pc_q    <= RESET_PC;
         issued_pc_q   <= '0;
         inflight_q    <= 1'b0;
         epoch_q       <= 1'b0;
         issue_epoch_q <= 1'b0;
      end else begin
         inflight_q <= issue;
         if (issue) begin
            issued_pc_q   <= fetch_pc_q;
            issue_epoch_q <= epoch_q;
         end
         if (redirect_valid) begin
            epoch_q    <= ~epoch_q;
            fetch_pc_q <= {redirect_pc[PC_WIDTH-1:1], 1'b0};
            state_q    <= RUN;
         end else begin
            if (issue) begin
               fetch_pc_q <= fetch_pc_q + PC_WIDTH'(2);
            end
            unique case (state_q)
               RUN: begin
                  if (resp_halt) begin
                     state_q <= HALT;
                  end else if (!in_range) begin
                     state_q <= FAULT;
                  end
               end
               HALT, FAULT: state_q <= state_q;
               default:     state_q <= FAULT;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_pdp_fetch_queue.sv
// Scoreboard bench for pdp_fetch_queue: a flash model plus expected (instr, pc, cycle) entries.
module tb_pdp_fetch_queue;

   typedef struct {
      logic [15:0] instr;
      logic [15:0] pc;
      int          cyc;
   } exp_t;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        flash_rd;
   logic [10:0] flash_addr;
   logic [15:0] flash_rdata;
   logic        redirect_valid = 1'b0;
   logic [15:0] redirect_pc = '0;
   logic        dec_valid;
   logic        dec_ready = 1'b0;
   logic [15:0] dec_instr;
   logic [15:0] dec_pc;
   logic [15:0] dec_next_pc;
   logic        halted;
   logic        fetch_fault;

   logic [15:0] mem [2048];
   exp_t        sb [$];
   int          n_tests = 0;
   int          n_fail = 0;
   int          cyc;
   int          rd_count = 0;
   int          last_rd_cyc = -1;
   int          rd_base;
   int          halt_cyc;
   logic        valid_seen;

   pdp_fetch_queue dut (
      .clock          (clock),
      .reset          (reset),
      .flash_rd       (flash_rd),
      .flash_addr     (flash_addr),
      .flash_rdata    (flash_rdata),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .dec_valid      (dec_valid),
      .dec_ready      (dec_ready),
      .dec_instr      (dec_instr),
      .dec_pc         (dec_pc),
      .dec_next_pc    (dec_next_pc),
      .halted         (halted),
      .fetch_fault    (fetch_fault)
   );

   always #5 clock = ~clock;

   always @(posedge clock) begin
      if (flash_rd) flash_rdata <= mem[flash_addr];
   end

   always @(posedge clock or posedge reset) begin
      if (reset) cyc <= 0;
      else       cyc <= cyc + 1;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   // Mid-cycle monitor: read counting and scoreboard pops on each handshake.
   always @(negedge clock) begin
      if (!reset && flash_rd) begin
         rd_count    <= rd_count + 1;
         last_rd_cyc <= cyc;
      end
      if (!reset && dec_valid && dec_ready) begin
         check("sb_has_entry", 32'(sb.size() != 0), 32'd1);
         if (sb.size() != 0) begin
            exp_t e;
            e = sb.pop_front();
            check("dec_instr", dec_instr, e.instr);
            check("dec_pc", dec_pc, e.pc);
            check("dec_next_pc", dec_next_pc, e.pc + 16'd2);
            if (e.cyc >= 0) check("dec_cycle", cyc, e.cyc);
         end
      end
   end

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic expect_at(input logic [15:0] pc, input int c);
      sb.push_back('{instr: mem[pc[11:1]], pc: pc, cyc: c});
   endtask

   // Leaves the bench at cycle 0 (+1) with reset released.
   task automatic do_reset(input bit chk);
      reset = 1'b1;
      redirect_valid = 1'b0;
      redirect_pc = '0;
      dec_ready = 1'b0;
      sb.delete();
      step();
      if (chk) begin
         check("rst_flash_rd", flash_rd, 1'b0);
         check("rst_dec_valid", dec_valid, 1'b0);
         check("rst_halted", halted, 1'b0);
         check("rst_fault", fetch_fault, 1'b0);
         check("rst_dec_instr", dec_instr, 16'd0);
         check("rst_dec_pc", dec_pc, 16'd0);
         check("rst_dec_next_pc", dec_next_pc, 16'd0);
      end
      @(posedge clock);
      #1;
      reset = 1'b0;
   endtask

   task automatic drain(input int bound, input bit rnd);
      int n = 0;
      while (sb.size() != 0 && n < bound) begin
         if (rnd) dec_ready = ($urandom_range(0, 2) != 0);
         step();
         n++;
      end
      dec_ready = 1'b0;
      check("drain_done", sb.size(), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      for (int i = 0; i < 2048; i++) mem[i] = 16'o100000 | 16'(i);
      mem[0] = 16'o060001;
      mem[1] = 16'o060000;
      mem[2] = 16'o027654;
      mem[3] = 16'o000000;

      // Sequential fetch ending in HALT
      do_reset(1'b1);
      rd_base = rd_count;
      halt_cyc = -1;
      dec_ready = 1'b1;
      expect_at(16'd0, 2);
      expect_at(16'd2, 3);
      expect_at(16'd4, 4);
      expect_at(16'd6, 5);
      for (int k = 0; k < 12; k++) begin
         if (halted && halt_cyc < 0) halt_cyc = k;
         step();
      end
      check("seq_halt_cycle", halt_cyc, 5);
      check("seq_read_count", rd_count - rd_base, 4);
      check("seq_last_read", last_rd_cyc, 3);
      check("seq_sb_empty", sb.size(), 0);
      dec_ready = 1'b0;

      // Backpressure
      mem[3] = 16'o012345;
      do_reset(1'b0);
      rd_base = rd_count;
      for (int k = 0; k < 10; k++) begin
         if (k == 3 || k == 9) begin
            check("bp_valid", dec_valid, 1'b1);
            check("bp_head_instr", dec_instr, 16'o060001);
            check("bp_head_pc", dec_pc, 16'd0);
         end
         step();
      end
      check("bp_read_count", rd_count - rd_base, 4);
      expect_at(16'd0, 10);
      for (int p = 2; p <= 14; p += 2) expect_at(16'(p), -1);
      dec_ready = 1'b1;
      drain(60, 1'b0);

      // Redirect with a read in flight
      do_reset(1'b0);
      dec_ready = 1'b1;
      expect_at(16'd0, 2);
      expect_at(16'd2, 3);
      expect_at(16'd4, 4);
      repeat (5) step();
      dec_ready = 1'b0;
      redirect_valid = 1'b1;
      redirect_pc = 16'o000021;
      step();
      redirect_valid = 1'b0;
      dec_ready = 1'b1;
      #1;
      check("redir_valid_n1", dec_valid, 1'b0);
      check("redir_rd_n1", flash_rd, 1'b1);
      check("redir_addr_n1", flash_addr, 11'd8);
      expect_at(16'o000020, 8);
      expect_at(16'o000022, 9);
      expect_at(16'o000024, 10);
      drain(40, 1'b0);

      // Out-of-range redirect, then recovery
      do_reset(1'b0);
      dec_ready = 1'b1;
      redirect_valid = 1'b1;
      redirect_pc = 16'o010000;
      rd_base = rd_count;
      valid_seen = 1'b0;
      step();
      redirect_valid = 1'b0;
      for (int k = 1; k < 8; k++) begin
         valid_seen = valid_seen | dec_valid;
         step();
      end
      check("oor_fault", fetch_fault, 1'b1);
      check("oor_halted", halted, 1'b1);
      check("oor_reads", rd_count - rd_base, 0);
      check("oor_valid_seen", valid_seen, 1'b0);
      check("oor_flash_rd", flash_rd, 1'b0);
      redirect_valid = 1'b1;
      redirect_pc = 16'd0;
      expect_at(16'd0, 11);
      expect_at(16'd2, 12);
      step();
      redirect_valid = 1'b0;
      check("oor_fault_clear", fetch_fault, 1'b0);
      drain(40, 1'b0);

      // Full queue with random backpressure: order and count preserved
      do_reset(1'b0);
      for (int i = 0; i < 24; i++) expect_at(16'(2 * i), -1);
      repeat (6) step();
      drain(400, 1'b1);

      // Asynchronous reset while the queue is full
      do_reset(1'b0);
      repeat (8) step();
      check("mid_pre_valid", dec_valid, 1'b1);
      #2;
      reset = 1'b1;
      #1;
      check("mid_valid", dec_valid, 1'b0);
      check("mid_instr", dec_instr, 16'd0);
      check("mid_pc", dec_pc, 16'd0);
      check("mid_next_pc", dec_next_pc, 16'd0);
      check("mid_flash_rd", flash_rd, 1'b0);
      do_reset(1'b0);
      dec_ready = 1'b1;
      expect_at(16'd0, 2);
      expect_at(16'd2, 3);
      drain(20, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
